// File: rtl/score_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : score_ctrl
//  Purpose  : Pong-style score keeper and game-flow controller. It tracks the
//             player and enemy scores, holds the ball after each goal for a
//             number of frames, blinks the winner's digit after game over, and
//             picks the serve direction.
//  Ports    : clk_i, rst_ni (async, active-low)
//             frame_tick_i        - one-cycle pulse at start of vblank
//             player_goal_i       - one-cycle pulse, player scored
//             enemy_goal_i        - one-cycle pulse, enemy scored
//             start_i             - one-cycle pulse, begin a new game
//             player_score_o[3:0], enemy_score_o[3:0] - displayed scores
//             player_vis_o, enemy_vis_o - score digit visible
//             freeze_o            - ball/paddles held
//             serve_dir_o         - 0 toward player, 1 toward enemy
//             game_over_o         - game finished
//             winner_o            - 0 player won, 1 enemy won
//  Revision : 1.0 - initial release
// ============================================================================
module score_ctrl #(
    parameter int MAX_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_tick_i,
    input  logic       player_goal_i,
    input  logic       enemy_goal_i,
    input  logic       start_i,
    output logic [3:0] player_score_o,
    output logic [3:0] enemy_score_o,
    output logic       player_vis_o,
    output logic       enemy_vis_o,
    output logic       freeze_o,
    output logic       serve_dir_o,
    output logic       game_over_o,
    output logic       winner_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [3:0] MAX_Q    = 4'(MAX_SCORE);
    localparam logic [7:0] PAUSE_LD = 8'(PAUSE_FRAMES);
    localparam logic [7:0] BLINK_LD = 8'(BLINK_FRAMES);

    logic [1:0] state_q,  state_d;
    logic [3:0] pscore_q, pscore_d;
    logic [3:0] escore_q, escore_d;
    logic       pend_q,   pend_d;
    logic       scorer_q, scorer_d;   // 0 = player, 1 = enemy
    logic [7:0] pcnt_q,   pcnt_d;
    logic [7:0] bcnt_q,   bcnt_d;
    logic       blink_q,  blink_d;    // blink phase of the winner's digit
    logic       pvis_q,   pvis_d;
    logic       evis_q,   evis_d;
    logic       freeze_q, freeze_d;
    logic       serve_q,  serve_d;
    logic       over_q,   over_d;
    logic       winner_q, winner_d;

    logic [3:0] cur_score;
    logic [3:0] new_score;

    // Score of the recorded scorer, incremented with saturation so a score
    // can never pass MAX_SCORE or wrap.
    always_comb begin
        cur_score = scorer_q ? escore_q : pscore_q;
        new_score = (cur_score < MAX_Q) ? cur_score + 4'd1 : cur_score;
    end

    always_comb begin
        state_d  = state_q;
        pscore_d = pscore_q;
        escore_d = escore_q;
        pend_d   = pend_q;
        scorer_d = scorer_q;
        pcnt_d   = pcnt_q;
        bcnt_d   = bcnt_q;
        blink_d  = blink_q;
        serve_d  = serve_q;
        winner_d = winner_q;

        if (start_i) begin
            // A start pulse restarts from any state and wins over a goal.
            state_d  = S_PAUSE;
            pscore_d = 4'd0;
            escore_d = 4'd0;
            pend_d   = 1'b0;
            scorer_d = 1'b0;
            pcnt_d   = PAUSE_LD;
            bcnt_d   = 8'd0;
            blink_d  = 1'b1;
            serve_d  = 1'b0;
            winner_d = 1'b0;
        end else begin
            case (state_q)
                S_PLAY: begin
                    if (pend_q && frame_tick_i) begin
                        // Apply the goal in vblank so digits change between frames.
                        pend_d  = 1'b0;
                        serve_d = ~scorer_q;
                        if (scorer_q) escore_d = new_score;
                        else          pscore_d = new_score;
                        if (new_score == MAX_Q) begin
                            state_d  = S_OVER;
                            winner_d = scorer_q;
                            bcnt_d   = BLINK_LD;
                            blink_d  = 1'b1;
                        end else begin
                            state_d = S_PAUSE;
                            pcnt_d  = PAUSE_LD;
                        end
                    end else if (!pend_q && (player_goal_i || enemy_goal_i)) begin
                        // Simultaneous goals credit the player.
                        pend_d   = 1'b1;
                        scorer_d = ~player_goal_i;
                    end
                end
                S_PAUSE: begin
                    if (frame_tick_i) begin
                        if (pcnt_q <= 8'd1) begin
                            state_d = S_PLAY;
                            pcnt_d  = 8'd0;
                        end else begin
                            pcnt_d = pcnt_q - 8'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (frame_tick_i) begin
                        if (bcnt_q <= 8'd1) begin
                            bcnt_d  = BLINK_LD;
                            blink_d = ~blink_q;
                        end else begin
                            bcnt_d = bcnt_q - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output flops are loaded from next-state values so every output is a
    // plain register while still tracking the state it belongs to.
    always_comb begin
        freeze_d = (state_d != S_PLAY) || pend_d;
        over_d   = (state_d == S_OVER);
        pvis_d   = !(over_d && !winner_d) || blink_d;
        evis_d   = !(over_d &&  winner_d) || blink_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pscore_q <= 4'd0;
            escore_q <= 4'd0;
            pend_q   <= 1'b0;
            scorer_q <= 1'b0;
            pcnt_q   <= 8'd0;
            bcnt_q   <= 8'd0;
            blink_q  <= 1'b1;
            pvis_q   <= 1'b1;
            evis_q   <= 1'b1;
            freeze_q <= 1'b1;
            serve_q  <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pscore_q <= pscore_d;
            escore_q <= escore_d;
            pend_q   <= pend_d;
            scorer_q <= scorer_d;
            pcnt_q   <= pcnt_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
            pvis_q   <= pvis_d;
            evis_q   <= evis_d;
            freeze_q <= freeze_d;
            serve_q  <= serve_d;
            over_q   <= over_d;
            winner_q <= winner_d;
        end
    end

    assign player_score_o = pscore_q;
    assign enemy_score_o  = escore_q;
    assign player_vis_o   = pvis_q;
    assign enemy_vis_o    = evis_q;
    assign freeze_o       = freeze_q;
    assign serve_dir_o    = serve_q;
    assign game_over_o    = over_q;
    assign winner_o       = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_score_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_ctrl
//  Purpose  : Self-checking bench for score_ctrl. A behavioural game model
//             predicts the outputs after every clock edge; predictions are
//             queued and a monitor compares them against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_ctrl;

    localparam int MAX = 9;
    localparam int PF  = 60;
    localparam int BF  = 16;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst_n, tick, pg, eg, start;
    logic [3:0] ps, es;
    logic       pv, ev, fr, sd, go, wn;

    always #5 clk = ~clk;

    score_ctrl #(.MAX_SCORE(MAX), .PAUSE_FRAMES(PF), .BLINK_FRAMES(BF)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .frame_tick_i   (tick),
        .player_goal_i  (pg),
        .enemy_goal_i   (eg),
        .start_i        (start),
        .player_score_o (ps),
        .enemy_score_o  (es),
        .player_vis_o   (pv),
        .enemy_vis_o    (ev),
        .freeze_o       (fr),
        .serve_dir_o    (sd),
        .game_over_o    (go),
        .winner_o       (wn)
    );

    typedef struct {
        int ps, es;
        bit pv, ev, fr, sd, go, wn;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    // Game model: the game phase plus counts of frames seen in that phase.
    int m_mode, m_ps, m_es, m_pause_ticks, m_over_ticks;
    bit m_pend, m_scorer, m_serve, m_winner;

    function automatic void model_reset();
        m_mode = M_IDLE; m_ps = 0; m_es = 0; m_pause_ticks = 0; m_over_ticks = 0;
        m_pend = 0; m_scorer = 0; m_serve = 0; m_winner = 0;
    endfunction

    function automatic void model_step(bit s, bit p, bit e, bit t);
        if (s) begin
            m_mode = M_PAUSE; m_ps = 0; m_es = 0; m_pend = 0;
            m_pause_ticks = 0; m_over_ticks = 0; m_serve = 0; m_winner = 0;
        end else begin
            case (m_mode)
                M_PLAY: begin
                    if (m_pend && t) begin
                        if (m_scorer) m_es++; else m_ps++;
                        m_pend  = 0;
                        m_serve = !m_scorer;     // serve toward whoever conceded
                        if ((m_scorer ? m_es : m_ps) == MAX) begin
                            m_mode = M_OVER; m_winner = m_scorer; m_over_ticks = 0;
                        end else begin
                            m_mode = M_PAUSE; m_pause_ticks = 0;
                        end
                    end else if (!m_pend && (p || e)) begin
                        m_pend = 1; m_scorer = p ? 1'b0 : 1'b1;
                    end
                end
                M_PAUSE: if (t) begin
                    m_pause_ticks++;
                    if (m_pause_ticks == PF) m_mode = M_PLAY;
                end
                M_OVER: if (t) m_over_ticks++;
                default: ;
            endcase
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit   on;
        on   = ((m_over_ticks / BF) % 2) == 0;
        e.ps = m_ps;
        e.es = m_es;
        e.go = (m_mode == M_OVER);
        e.wn = m_winner;
        e.pv = !(e.go && !m_winner) || on;
        e.ev = !(e.go &&  m_winner) || on;
        e.fr = (m_mode != M_PLAY) || m_pend;
        e.sd = m_serve;
        return e;
    endfunction

    task automatic compare(string tag, exp_t e, bit chk_w);
        n_vec++;
        if (int'(ps) != e.ps || int'(es) != e.es || pv !== e.pv || ev !== e.ev ||
            fr !== e.fr || sd !== e.sd || go !== e.go || (chk_w && wn !== e.wn)) begin
            n_err++;
            $display("FAIL %s @%0t: got ps=%0d es=%0d pv=%b ev=%b fr=%b sd=%b go=%b wn=%b, expected ps=%0d es=%0d pv=%b ev=%b fr=%b sd=%b go=%b wn=%b",
                     tag, $time, ps, es, pv, ev, fr, sd, go, wn,
                     e.ps, e.es, e.pv, e.ev, e.fr, e.sd, e.go, e.wn);
        end
    endtask

    // Monitor: one prediction is queued per clock edge.
    always begin
        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            cur = q.pop_front();
            compare("vec", cur, cur.go);
        end
    end

    task automatic cyc(bit r, bit s, bit p, bit e, bit t);
        @(negedge clk);
        rst_n = r; start = s; pg = p; eg = e; tick = t;
        if (!r) model_reset();
        else    model_step(s, p, e, t);
        q.push_back(model_out());
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(int n);
        repeat (n) begin
            cyc(1, 0, 0, 0, 1);
            cyc(1, 0, 0, 0, 0);
        end
    endtask

    // Score one goal from PAUSE: finish the pause, goal, then the applying tick.
    task automatic score(bit enemy);
        ticks(PF);
        cyc(1, 0, !enemy, enemy, 0);
        idle(2);
        cyc(1, 0, 0, 0, 1);
        idle(1);
    endtask

    // Reset checked mid-cycle, before any clock edge can act.
    task automatic async_reset();
        @(negedge clk);
        rst_n = 0; start = 0; pg = 0; eg = 0; tick = 0;
        #1;
        model_reset();
        compare("async_rst", model_out(), 1'b1);
        q.push_back(model_out());
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; pg = 0; eg = 0; tick = 0;
        model_reset();
        #12;
        compare("reset", model_out(), 1'b1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(2);

        // New game, pause expires after PF ticks.
        cyc(1, 1, 0, 0, 0);
        ticks(PF);
        idle(2);
        // Player goal, held until the next tick.
        cyc(1, 0, 1, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 1);
        idle(2);
        // Both goals together, then a second goal before the tick.
        ticks(PF);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        cyc(1, 0, 0, 0, 1);
        idle(1);
        // Enemy runs to MAX.
        repeat (MAX) score(1'b1);
        // Blink while goals keep arriving.
        repeat (40) begin
            cyc(1, 0, 1'($urandom % 2), 1'($urandom % 2), 1);
            cyc(1, 0, 0, 0, 0);
        end
        // Restart from OVER.
        cyc(1, 1, 0, 0, 0);
        idle(2);
        // Reach 3/2 and reset in PAUSE.
        score(0); score(1); score(0); score(1); score(0);
        ticks(5);
        async_reset();
        idle(2);
        // Start coincident with a goal during play.
        cyc(1, 1, 0, 0, 0);
        ticks(PF);
        cyc(1, 1, 1, 0, 0);
        idle(3);

        // Randomised play.
        for (int i = 0; i < 25000; i++) begin
            bit s, p, e, t;
            if ($urandom % 9000 == 0) begin
                async_reset();
            end else begin
                if (m_mode == M_IDLE || m_mode == M_OVER) s = ($urandom % 150 == 0);
                else                                        s = ($urandom % 9000 == 0);
                p = ($urandom % 12 == 0);
                e = ($urandom % 12 == 0);
                t = ($urandom % 3 == 0);
                cyc(1, s, p, e, t);
            end
        end

        idle(2);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter MAX_SCORE, default 9, winning score; legal range 1..15.
REQ-002 Parameter PAUSE_FRAMES, default 60, frames the ball is held after a goal; legal range 1..255.
REQ-003 Parameter BLINK_FRAMES, default 16, half-period in frames of the winner-score blink after game over; legal range 1..255.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 frame_tick_i  in  1  one-cycle pulse at start of vertical blanking.
REQ-007 player_goal_i  in  1  one-cycle pulse; player scored.
REQ-008 enemy_goal_i  in  1  one-cycle pulse; enemy scored.
REQ-009 start_i  in  1  one-cycle pulse; begin a new game.
REQ-010 player_score_o  out  4  player score shown on display.
REQ-011 enemy_score_o  out  4  enemy score shown on display.
REQ-012 player_vis_o / enemy_vis_o  out  1 each  score digit visible (blink control).
REQ-013 freeze_o  out  1  ball/paddles held when high.
REQ-014 serve_dir_o  out  1  0 = serve toward player, 1 = toward enemy.
REQ-015 game_over_o  out  1  high while in OVER.
REQ-016 winner_o  out  1  0 = player won, 1 = enemy won; valid only while game_over_o is high.

Function
REQ-017 The FSM SHALL have four states: IDLE, PLAY, PAUSE, OVER.
REQ-018 IDLE: freeze_o=1; start_i -> PAUSE with both scores 0, pause counter loaded with PAUSE_FRAMES, serve_dir_o=0.
REQ-019 PLAY: freeze_o=0; a goal pulse sets a pending flag and records the scorer; goal pulses in IDLE, PAUSE and OVER SHALL be ignored.
REQ-020 A player_goal_i and enemy_goal_i in the same cycle SHALL credit the player only.
REQ-021 Only the first goal of a rally SHALL be recorded; further goals SHALL be ignored while the pending flag is set.
REQ-022 freeze_o SHALL go high the cycle after a goal is recorded.
REQ-023 A pending goal SHALL be applied in the cycle of the next frame_tick_i: the scorer's score increments by 1, the pending flag clears, and the score outputs change one cycle later, so displayed digits never change mid-frame.
REQ-024 On apply, a new score equal to MAX_SCORE -> OVER with winner_o = scorer; otherwise -> PAUSE with the counter loaded with PAUSE_FRAMES.
REQ-025 On apply, serve_dir_o SHALL point toward the player who conceded.
REQ-026 PAUSE: freeze_o=1; the counter decrements on each frame_tick_i; a tick at counter value 1 -> PLAY.
REQ-027 Scores SHALL never exceed MAX_SCORE and SHALL never wrap.
REQ-028 OVER: freeze_o=1 and game_over_o=1; the loser's vis output stays 1; the winner's vis output toggles every BLINK_FRAMES frame ticks, starting at 1.
REQ-029 OVER: start_i SHALL act exactly as in IDLE (REQ-018).
REQ-030 start_i in PLAY or PAUSE SHALL restart the game as in REQ-018 and clear any pending goal.
REQ-031 start_i coincident with a goal SHALL take priority over the goal.
REQ-032 Outside OVER, both vis outputs SHALL be 1.
REQ-033 All outputs SHALL be driven directly from flops.

Reset
REQ-034 While rst_ni=0, asynchronously: state IDLE, scores 0, pending flag 0, counters 0, freeze_o=1, serve_dir_o=0, game_over_o=0, winner_o=0, both vis outputs 1.
REQ-035 Reset deasserted mid-game SHALL resume in IDLE with the REQ-034 values; no goal is credited.

Verification
REQ-036 Reset, start_i, 60 frame ticks -> freeze_o falls after the 60th tick; scores 0/0.
REQ-037 PLAY, player_goal_i -> freeze_o=1 next cycle; player_score_o stays 0 until the next frame_tick_i, then reads 1; serve_dir_o=1.
REQ-038 Both goal inputs in the same cycle -> player 1, enemy 0; a second goal before the tick -> no further change.
REQ-039 Enemy reaches 9 -> game_over_o=1, winner_o=1; enemy_vis_o toggles every 16 ticks; player_vis_o stays 1; further goals ignored.
REQ-040 rst_ni pulsed low in PAUSE with score 3/2 -> outputs return to REQ-034 values immediately, without a clock edge.
REQ-041 start_i in OVER -> scores 0/0, PAUSE, game_over_o=0, both vis outputs 1.
